// File: rtl/hdmi_timing_ctrl.sv
// -----------------------------------------------------------------------------
// hdmi_timing_ctrl
//
// Video timing sequencer for the HDMI output path. It walks a parameterised
// raster one pixel per clock and produces registered sync, data-enable and
// pixel coordinates that all line up in the same cycle. A single level enable
// starts and stops the raster. A stop request always finishes the frame that
// is in progress, so a partial frame is never emitted.
//
// Ports
//   clk          pixel clock, rising edge
//   rst          asynchronous, active-low reset
//   en           run request (level)
//   h_sync       horizontal sync, asserted level = H_POL
//   v_sync       vertical sync, asserted level = V_POL
//   data_en      high while (x, y) is a visible pixel
//   x, y         current pixel position (12 bits each)
//   line_start   one-cycle pulse on x == 0 while running
//   frame_start  one-cycle pulse on x == 0, y == 0 while running
//   busy         high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module hdmi_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        h_sync,
    output logic        v_sync,
    output logic        data_en,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        line_start,
    output logic        frame_start,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
            $error("hdmi_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 4096");
        end
    endgenerate

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // Window bounds are 13 bits wide so that a bound equal to 4096 still fits.
    localparam logic [12:0] H_DE_END = 13'(H_ACTIVE);
    localparam logic [12:0] H_SY_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SY_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_DE_END = 13'(V_ACTIVE);
    localparam logic [12:0] V_SY_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SY_END = 13'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t      state;

    logic        x_wrap;
    logic        y_wrap;
    logic        frame_end;
    logic        running_nxt;
    logic [11:0] x_nxt;
    logic [11:0] y_nxt;
    logic        de_nxt;
    logic        hs_act_nxt;
    logic        vs_act_nxt;

    // NOTE: every signal gets a value on every path through this block;
    // otherwise synthesis infers a latch to hold the missing case.
    always_comb begin
        x_wrap    = (x == H_LAST);
        y_wrap    = (y == V_LAST);
        frame_end = x_wrap && y_wrap;

        // Leaving IDLE always starts at the origin of a fresh frame.
        if (state == IDLE) begin
            x_nxt = '0;
            y_nxt = '0;
        end else if (x_wrap) begin
            x_nxt = '0;
            y_nxt = y_wrap ? 12'd0 : y + 12'd1;
        end else begin
            x_nxt = x + 12'd1;
            y_nxt = y;
        end

        // Whether the next cycle shows a pixel or idle values. DRAIN stops
        // only after the last pixel of the frame, unless en came back.
        case (state)
            IDLE:    running_nxt = en;
            DRAIN:   running_nxt = en || !frame_end;
            default: running_nxt = 1'b1;
        endcase

        de_nxt     = ({1'b0, x_nxt} < H_DE_END) && ({1'b0, y_nxt} < V_DE_END);
        hs_act_nxt = ({1'b0, x_nxt} >= H_SY_BEG) && ({1'b0, x_nxt} < H_SY_END);
        // y only moves when x wraps, so v_sync changes only alongside x == 0.
        vs_act_nxt = ({1'b0, y_nxt} >= V_SY_BEG) && ({1'b0, y_nxt} < V_SY_END);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            data_en     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (en) state <= RUN;
                RUN:  if (!en) state <= DRAIN;
                DRAIN: begin
                    if (en)             state <= RUN;
                    else if (frame_end) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (running_nxt) begin
                x           <= x_nxt;
                y           <= y_nxt;
                h_sync      <= hs_act_nxt ? H_POL : ~H_POL;
                v_sync      <= vs_act_nxt ? V_POL : ~V_POL;
                data_en     <= de_nxt;
                line_start  <= (x_nxt == 12'd0);
                frame_start <= (x_nxt == 12'd0) && (y_nxt == 12'd0);
                busy        <= 1'b1;
            end else begin
                x           <= '0;
                y           <= '0;
                h_sync      <= ~H_POL;
                v_sync      <= ~V_POL;
                data_en     <= 1'b0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hdmi_timing_ctrl
//
// Directed bench for hdmi_timing_ctrl. Three instances share one clock and
// reset:
//   u_a  default 800x525 raster (reset behaviour, line timing)
//   u_m  medium raster 24x17, 408-cycle frames (frame timing, drain,
//        back-to-back)
//   u_s  small raster 8x6, positive sync polarity (cycle-by-cycle model)
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_hdmi_timing_ctrl;

    logic clk;
    logic rst;
    logic en_a, en_m, en_s;

    int checks = 0;
    int errors = 0;

    logic        hs_a, vs_a, de_a, ls_a, fs_a, busy_a;
    logic [11:0] x_a, y_a;
    logic        hs_m, vs_m, de_m, ls_m, fs_m, busy_m;
    logic [11:0] x_m, y_m;
    logic        hs_s, vs_s, de_s, ls_s, fs_s, busy_s;
    logic [11:0] x_s, y_s;

    // Packed view: {h_sync, v_sync, data_en, line_start, frame_start, busy, x, y}
    logic [29:0] vec_a, vec_m, vec_s;
    assign vec_a = {hs_a, vs_a, de_a, ls_a, fs_a, busy_a, x_a, y_a};
    assign vec_m = {hs_m, vs_m, de_m, ls_m, fs_m, busy_m, x_m, y_m};
    assign vec_s = {hs_s, vs_s, de_s, ls_s, fs_s, busy_s, x_s, y_s};

    hdmi_timing_ctrl u_a (
        .clk(clk), .rst(rst), .en(en_a),
        .h_sync(hs_a), .v_sync(vs_a), .data_en(de_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a), .busy(busy_a)
    );

    hdmi_timing_ctrl #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b0), .V_POL(1'b0)
    ) u_m (
        .clk(clk), .rst(rst), .en(en_m),
        .h_sync(hs_m), .v_sync(vs_m), .data_en(de_m), .x(x_m), .y(y_m),
        .line_start(ls_m), .frame_start(fs_m), .busy(busy_m)
    );

    hdmi_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_s (
        .clk(clk), .rst(rst), .en(en_s),
        .h_sync(hs_s), .v_sync(vs_s), .data_en(de_s), .x(x_s), .y(y_s),
        .line_start(ls_s), .frame_start(fs_s), .busy(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected output vector c cycles after the first running cycle of a frame
    // sequence; c < 0 gives the idle vector.
    function automatic logic [29:0] exp_vec(input int ha, input int hf, input int hs,
                                            input int hb, input int va, input int vf,
                                            input int vs, input int vb, input logic hp,
                                            input logic vp, input int c);
        int   ht, vt, px, py;
        logic s_h, s_v, de;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (c < 0) return {~hp, ~vp, 4'b0000, 24'd0};
        px  = c % ht;
        py  = (c / ht) % vt;
        de  = (px < ha) && (py < va);
        s_h = (px >= ha + hf && px < ha + hf + hs) ? hp : ~hp;
        s_v = (py >= va + vf && py < va + vf + vs) ? vp : ~vp;
        return {s_h, s_v, de, px == 0, (px == 0) && (py == 0), 1'b1, 12'(px), 12'(py)};
    endfunction

    function automatic logic [29:0] exp_a(input int c);
        return exp_vec(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, c);
    endfunction

    function automatic logic [29:0] exp_m(input int c);
        return exp_vec(16, 2, 3, 3, 10, 2, 2, 3, 1'b0, 1'b0, c);
    endfunction

    task automatic wait_idle_m();
        bit done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (busy_m === 1'b0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle_m: busy=%b still high after 1000 cycles, required 0", busy_m);
        end
    endtask

    task automatic test_reset();
        bit found = 0;
        rst = 1'b0; en_a = 1'b0; en_m = 1'b0; en_s = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (vec_a !== exp_a(-1)) begin
            errors++; $display("FAIL reset_a: got %h, expected %h", vec_a, exp_a(-1));
        end
        checks++;
        if (vec_m !== exp_m(-1)) begin
            errors++; $display("FAIL reset_m: got %h, expected %h", vec_m, exp_m(-1));
        end
        checks++;
        if (vec_s !== 30'd0) begin
            errors++; $display("FAIL reset_s: got %h, expected %h", vec_s, 30'd0);
        end

        rst = 1'b1;
        @(negedge clk);
        en_a = 1'b1;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (x_a == 12'd300) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL reset_reach_x300: x=%0d, required 300", x_a);
        end

        // Assert reset mid-cycle and check before the next rising edge.
        #2 rst = 1'b0;
        #1;
        checks++;
        if (vec_a !== exp_a(-1)) begin
            errors++; $display("FAIL async_reset: got %h, expected %h", vec_a, exp_a(-1));
        end

        @(negedge clk);
        en_a = 1'b0;
        rst  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            checks++;
            if (vec_a !== exp_a(-1)) begin
                errors++; $display("FAIL idle_hold cyc=%0d: got %h, expected %h", i, vec_a, exp_a(-1));
            end
        end
    endtask

    task automatic test_line_timing();
        int de_cnt = 0, hs_cnt = 0, hs_first = -1, ls_cnt = 0;
        @(negedge clk);
        en_a = 1'b1;
        for (int c = 0; c < 2400; c++) begin
            @(negedge clk);
            checks++;
            if (vec_a !== exp_a(c)) begin
                errors++; $display("FAIL line_timing c=%0d: got %h, expected %h", c, vec_a, exp_a(c));
            end
            if (c < 800) begin
                if (de_a) de_cnt++;
                if (!hs_a) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = c;
                end
            end
            if (ls_a) ls_cnt++;
        end
        en_a = 1'b0;
        checks++;
        if (de_cnt !== 640) begin
            errors++; $display("FAIL line_de_count: got %0d, expected 640", de_cnt);
        end
        checks++;
        if (hs_first !== 656) begin
            errors++; $display("FAIL line_hsync_start: got %0d, expected 656", hs_first);
        end
        checks++;
        if (hs_cnt !== 96) begin
            errors++; $display("FAIL line_hsync_width: got %0d, expected 96", hs_cnt);
        end
        checks++;
        if (ls_cnt !== 3) begin
            errors++; $display("FAIL line_start_count: got %0d, expected 3", ls_cnt);
        end
    endtask

    task automatic test_frame_timing();
        int   de_cnt[2], vs_cnt[2], vs_first[2];
        int   vs_bad = 0, last_fs = -1, spacing = -1, f;
        logic vs_prev;
        for (int i = 0; i < 2; i++) begin
            de_cnt[i] = 0; vs_cnt[i] = 0; vs_first[i] = -1;
        end
        vs_prev = 1'b1;
        @(negedge clk);
        en_m = 1'b1;
        for (int c = 0; c < 816; c++) begin
            @(negedge clk);
            checks++;
            if (vec_m !== exp_m(c)) begin
                errors++; $display("FAIL frame_timing c=%0d: got %h, expected %h", c, vec_m, exp_m(c));
            end
            f = c / 408;
            if (de_m) de_cnt[f]++;
            if (!vs_m) begin
                vs_cnt[f]++;
                if (vs_first[f] < 0) vs_first[f] = c % 408;
            end
            if (vs_m !== vs_prev && x_m !== 12'd0) vs_bad++;
            if (fs_m) begin
                if (last_fs >= 0) spacing = c - last_fs;
                last_fs = c;
            end
            vs_prev = vs_m;
        end
        en_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (de_cnt[i] !== 160) begin
                errors++; $display("FAIL frame_de_count f=%0d: got %0d, expected 160", i, de_cnt[i]);
            end
            checks++;
            if (vs_cnt[i] !== 48) begin
                errors++; $display("FAIL frame_vsync_width f=%0d: got %0d, expected 48", i, vs_cnt[i]);
            end
            checks++;
            if (vs_first[i] !== 288) begin
                errors++; $display("FAIL frame_vsync_start f=%0d: got %0d, expected 288", i, vs_first[i]);
            end
        end
        checks++;
        if (vs_bad !== 0) begin
            errors++; $display("FAIL vsync_edge_at_x0: %0d edges away from x=0, expected 0", vs_bad);
        end
        checks++;
        if (spacing !== 408) begin
            errors++; $display("FAIL frame_start_spacing: got %0d, expected 408", spacing);
        end
        wait_idle_m();
    endtask

    // Drop en early in the frame (optionally pulse it later); the frame must
    // complete undisturbed and busy must fall exactly 408 cycles after start.
    task automatic test_drain(input bit pulse);
        logic [29:0] e;
        @(negedge clk);
        en_m = 1'b1;
        for (int c = 0; c < 412; c++) begin
            @(negedge clk);
            e = (c < 408) ? exp_m(c) : exp_m(-1);
            checks++;
            if (vec_m !== e) begin
                errors++; $display("FAIL drain pulse=%0d c=%0d: got %h, expected %h", pulse, c, vec_m, e);
            end
            if (c == 72) en_m = 1'b0;
            if (pulse && c == 144) en_m = 1'b1;
            if (pulse && c == 145) en_m = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        en_m = 1'b1;
        for (int c = 0; c < 456; c++) begin
            @(negedge clk);
            checks++;
            if (vec_m !== exp_m(c)) begin
                errors++; $display("FAIL back_to_back c=%0d: got %h, expected %h", c, vec_m, exp_m(c));
            end
            if (c == 100) en_m = 1'b0;
            if (c == 407) en_m = 1'b1;
        end
        en_m = 1'b0;
        wait_idle_m();
    endtask

    // Independent counter model of the 8x6 raster with positive polarities.
    task automatic test_small_raster();
        int          mx = 0, my = 0;
        logic [29:0] e;
        @(negedge clk);
        en_s = 1'b1;
        for (int c = 0; c < 146; c++) begin
            @(negedge clk);
            if (c < 144)
                e = {(mx >= 5 && mx < 7), (my == 4), (mx < 4 && my < 3), (mx == 0),
                     (mx == 0 && my == 0), 1'b1, 12'(mx), 12'(my)};
            else
                e = 30'd0;
            checks++;
            if (vec_s !== e) begin
                errors++; $display("FAIL small_raster c=%0d: got %h, expected %h", c, vec_s, e);
            end
            mx++;
            if (mx == 8) begin
                mx = 0;
                my++;
                if (my == 6) my = 0;
            end
            if (c == 100) en_s = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_drain(1'b0);
        test_drain(1'b1);
        test_back_to_back();
        test_small_raster();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
